// File: rtl/aclk_set_controller.sv
// Alarm-clock keypad sequencer: collects four BCD digits and commits them to the time counter or the alarm.
// Optional build macro ACLK_DIGIT_CHECK_EN range-checks the digits on commit and pulses entry_error on rejection.
module aclk_set_controller #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic [3:0] new_ms_hr,
    output logic [3:0] new_ls_hr,
    output logic [3:0] new_ms_min,
    output logic [3:0] new_ls_min,
    output logic       load_new_c,
    output logic       load_new_a,
    output logic       show_new_time,
    output logic       show_a,
    output logic [2:0] entry_count,
    output logic       entry_error
);

    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        KEY_ENTRY  = 3'd1,
        SHOW_ALARM = 3'd2,
        LOAD_C     = 3'd3,
        LOAD_A     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        load_c_q, load_c_d;
    logic        load_a_q, load_a_d;
    logic        show_new_q, show_new_d;
    logic        show_a_q, show_a_d;
    logic        err_q, err_d;
    logic        digit_s;
    logic        expire_s;
    logic        commit_ok_s;

    // Legal HH:MM: hours tens 0..2, minutes tens 0..5, hours units 0..3 when hours tens is 2.
    function automatic logic digits_in_range(input logic [15:0] b);
        logic ok;
        ok = (b[15:12] <= 4'd2) && (b[7:4] <= 4'd5);
        if (b[15:12] == 4'd2) begin
            ok = ok && (b[11:8] <= 4'd3);
        end
        return ok;
    endfunction

    assign digit_s  = key_valid && (key <= 4'd9);
    assign expire_s = one_second && (timer_q == TW'(TIMEOUT_SEC - 1));

`ifdef ACLK_DIGIT_CHECK_EN
    assign commit_ok_s = digits_in_range(buf_q);
`else
    assign commit_ok_s = 1'b1;
`endif

    // Next-state, key buffer, entry counter and inactivity timer.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        load_c_d = 1'b0;
        load_a_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                buf_d   = 16'h0000;
                cnt_d   = 3'd0;
                timer_d = '0;
                if (alarm_button) begin
                    state_d = SHOW_ALARM;
                end else if (digit_s) begin
                    state_d = KEY_ENTRY;
                    buf_d   = {12'h000, key};
                    cnt_d   = 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            KEY_ENTRY: begin
                if (time_button) begin
                    state_d = (cnt_q == 3'd4) ? LOAD_C : IDLE;
                    timer_d = '0;
                end else if (alarm_button) begin
                    state_d = (cnt_q == 3'd4) ? LOAD_A : IDLE;
                    timer_d = '0;
                end else if (digit_s && (cnt_q != 3'd4)) begin
                    buf_d   = {buf_q[11:0], key};
                    cnt_d   = cnt_q + 3'd1;
                    timer_d = '0;
                end else if (expire_s) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (one_second) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            SHOW_ALARM: begin
                if (alarm_button) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (digit_s) begin
                    state_d = KEY_ENTRY;
                    buf_d   = {12'h000, key};
                    cnt_d   = 3'd1;
                    timer_d = '0;
                end else if (expire_s) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (one_second) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            // Buffer is held through the load cycle; IDLE clears it on the following edge.
            LOAD_C: begin
                state_d  = IDLE;
                load_c_d = commit_ok_s;
                err_d    = !commit_ok_s;
            end
            LOAD_A: begin
                state_d  = IDLE;
                load_a_d = commit_ok_s;
                err_d    = !commit_ok_s;
            end
            default: begin
                state_d = IDLE;
                buf_d   = 16'h0000;
                cnt_d   = 3'd0;
                timer_d = '0;
            end
        endcase
        show_new_d = (state_d == KEY_ENTRY);
        show_a_d   = (state_d == SHOW_ALARM);
    end

    // State and registered outputs; synchronous reset wins over every event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            buf_q      <= 16'h0000;
            cnt_q      <= 3'd0;
            timer_q    <= '0;
            load_c_q   <= 1'b0;
            load_a_q   <= 1'b0;
            show_new_q <= 1'b0;
            show_a_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            load_c_q   <= load_c_d;
            load_a_q   <= load_a_d;
            show_new_q <= show_new_d;
            show_a_q   <= show_a_d;
            err_q      <= err_d;
        end
    end

    assign new_ms_hr     = buf_q[15:12];
    assign new_ls_hr     = buf_q[11:8];
    assign new_ms_min    = buf_q[7:4];
    assign new_ls_min    = buf_q[3:0];
    assign load_new_c    = load_c_q;
    assign load_new_a    = load_a_q;
    assign show_new_time = show_new_q;
    assign show_a        = show_a_q;
    assign entry_count   = cnt_q;
    assign entry_error   = err_q;

endmodule
